// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: register file, immediate generation, operand-B mux, pipeline register
module decode_stage (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        instr_ready_out,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_data_in,
    output logic        valid_out,
    output logic [6:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic [6:0]  funct7_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rs1_value_out,
    output logic [31:0] rs2_value_out,
    output logic [31:0] mux_result_out,
    output logic [31:0] imm_out,
    output logic [31:0] pc_out,
    output logic        illegal_out
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] regs [1:31];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] imm;
    logic [31:0] operand_b;
    logic        legal_op;
    logic        illegal;

    assign opcode  = instr_in[6:0];
    assign funct3  = instr_in[14:12];
    assign funct7  = instr_in[31:25];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];

    assign instr_ready_out = !stall_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_in && wb_rd_in != 5'd0) begin
            regs[wb_rd_in] <= wb_data_in;
        end
    end

    // Same-cycle writeback is forwarded so the entry never captures a stale value.
    always_comb begin
        rs1_value = '0;
        rs2_value = '0;
        if (rs1_idx != 5'd0) begin
            rs1_value = (wb_en_in && wb_rd_in == rs1_idx) ? wb_data_in : regs[rs1_idx];
        end
        if (rs2_idx != 5'd0) begin
            rs2_value = (wb_en_in && wb_rd_in == rs2_idx) ? wb_data_in : regs[rs2_idx];
        end
    end

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr_in[31]}}, instr_in[31:20]};
            OP_STORE:  imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            OP_BRANCH: imm = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {instr_in[31:12], 12'b0};
            OP_JAL:    imm = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                              instr_in[20], instr_in[30:21], 1'b0};
            default:   imm = '0;
        endcase
    end

    assign operand_b = (opcode == OP_REG || opcode == OP_BRANCH) ? rs2_value : imm;

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
    end

    // funct7 = 0100000 is only meaningful for SUB and SRA.
    assign illegal = !legal_op
                  || (opcode == OP_REG && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                  || (opcode == OP_REG && funct7 == 7'b0100000
                      && funct3 != 3'b000 && funct3 != 3'b101);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out      <= 1'b0;
            opcode_out     <= '0;
            funct3_out     <= '0;
            funct7_out     <= '0;
            rd_out         <= '0;
            rs1_value_out  <= '0;
            rs2_value_out  <= '0;
            mux_result_out <= '0;
            imm_out        <= '0;
            pc_out         <= '0;
            illegal_out    <= 1'b0;
        end else if (flush_in) begin
            valid_out <= 1'b0;
        end else if (!stall_in) begin
            valid_out      <= instr_valid_in;
            opcode_out     <= opcode;
            funct3_out     <= funct3;
            funct7_out     <= funct7;
            rd_out         <= instr_in[11:7];
            rs1_value_out  <= rs1_value;
            rs2_value_out  <= rs2_value;
            mux_result_out <= operand_b;
            imm_out        <= imm;
            pc_out         <= pc_in;
            illegal_out    <= illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed table-driven bench for decode_stage
module tb_decode_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_ready_out;
    logic        stall_in;
    logic        flush_in;
    logic        wb_en_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_data_in;
    logic        valid_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rd_out;
    logic [31:0] rs1_value_out;
    logic [31:0] rs2_value_out;
    logic [31:0] mux_result_out;
    logic [31:0] imm_out;
    logic [31:0] pc_out;
    logic        illegal_out;

    int tests = 0;
    int fails = 0;

    decode_stage dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .instr_valid_in(instr_valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .instr_ready_out(instr_ready_out), .stall_in(stall_in), .flush_in(flush_in),
        .wb_en_in(wb_en_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
        .valid_out(valid_out), .opcode_out(opcode_out), .funct3_out(funct3_out),
        .funct7_out(funct7_out), .rd_out(rd_out), .rs1_value_out(rs1_value_out),
        .rs2_value_out(rs2_value_out), .mux_result_out(mux_result_out),
        .imm_out(imm_out), .pc_out(pc_out), .illegal_out(illegal_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] instr;
        logic        vin;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        evalid;
        logic [6:0]  eop;
        logic [2:0]  ef3;
        logic [4:0]  erd;
        logic [31:0] ers1;
        logic [31:0] ers2;
        logic [31:0] emux;
        logic [31:0] eimm;
        logic        eill;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] instr, input logic vin, input logic wen,
                       input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic evalid, input logic [6:0] eop, input logic [2:0] ef3,
                       input logic [4:0] erd, input logic [31:0] ers1, input logic [31:0] ers2,
                       input logic [31:0] emux, input logic [31:0] eimm, input logic eill);
        vec_t v;
        v.instr = instr; v.vin = vin; v.wen = wen; v.wrd = wrd; v.wdata = wdata;
        v.evalid = evalid; v.eop = eop; v.ef3 = ef3; v.erd = erd; v.ers1 = ers1;
        v.ers2 = ers2; v.emux = emux; v.eimm = eimm; v.eill = eill;
        vq.push_back(v);
    endtask

    task automatic drive(input logic vin, input logic [31:0] instr, input logic [31:0] pc,
                         input logic stall, input logic flush, input logic wen,
                         input logic [4:0] wrd, input logic [31:0] wdata);
        instr_valid_in = vin; instr_in = instr; pc_in = pc;
        stall_in = stall; flush_in = flush;
        wb_en_in = wen; wb_rd_in = wrd; wb_data_in = wdata;
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        //   instr         vin wen rd  wdata         valid op     f3  rd  rs1           rs2           mux           imm           ill
        add(32'hFFB00093, 1, 0, 0,  32'h0,        1, 7'h13, 0, 1,  32'h0,        32'h0,        32'hFFFFFFFB, 32'hFFFFFFFB, 0);
        add(32'h00528333, 1, 1, 5,  32'h00001234, 1, 7'h33, 0, 6,  32'h00001234, 32'h00001234, 32'h00001234, 32'h0,        0);
        add(32'h005003B3, 1, 1, 0,  32'h0000DEAD, 1, 7'h33, 0, 7,  32'h0,        32'h00001234, 32'h00001234, 32'h0,        0);
        add(32'h00000433, 1, 0, 0,  32'h0,        1, 7'h33, 0, 8,  32'h0,        32'h0,        32'h0,        32'h0,        0);
        add(32'h00000000, 0, 1, 3,  32'h00000010, 0, 7'h00, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        1);
        add(32'h4041D113, 1, 0, 0,  32'h0,        1, 7'h13, 5, 2,  32'h00000010, 32'h0,        32'h00000404, 32'h00000404, 0);
        add(32'hFE418CE3, 1, 1, 4,  32'h00000055, 1, 7'h63, 0, 25, 32'h00000010, 32'h00000055, 32'h00000055, 32'hFFFFFFF8, 0);
        add(32'hABCDE0B7, 1, 0, 0,  32'h0,        1, 7'h37, 6, 1,  32'h0,        32'h0,        32'hABCDE000, 32'hABCDE000, 0);
        add(32'h0000007F, 1, 0, 0,  32'h0,        1, 7'h7F, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        1);
        add(32'h022080B3, 1, 0, 0,  32'h0,        1, 7'h33, 0, 1,  32'h0,        32'h0,        32'h0,        32'h0,        1);
        add(32'h40001033, 1, 0, 0,  32'h0,        1, 7'h33, 1, 0,  32'h0,        32'h0,        32'h0,        32'h0,        1);
        add(32'h403284B3, 1, 0, 0,  32'h0,        1, 7'h33, 0, 9,  32'h00001234, 32'h00000010, 32'h00000010, 32'h0,        0);
        add(32'hFE41AE23, 1, 0, 0,  32'h0,        1, 7'h23, 2, 28, 32'h00000010, 32'h00000055, 32'hFFFFFFFC, 32'hFFFFFFFC, 0);
        add(32'h010000EF, 1, 0, 0,  32'h0,        1, 7'h6F, 0, 1,  32'h0,        32'h0,        32'h00000010, 32'h00000010, 0);

        rst_in = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        step;
        step;
        chk("rst_ready", {31'd0, instr_ready_out}, 32'd1);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_mux", mux_result_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ill", {31'd0, illegal_out}, 32'd0);
        rst_in = 1'b0;

        for (int i = 1; i < 32; i++) begin
            logic [31:0] w;
            w = (32'(i) << 20) | (32'(i) << 15) | 32'h33;
            drive(1, w, 32'h0, 0, 0, 0, 0, 32'h0);
            step;
            chk($sformatf("rst_x%0d_rs1", i), rs1_value_out, 32'h0);
            chk($sformatf("rst_x%0d_rs2", i), rs2_value_out, 32'h0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(i) * 4;
            drive(vq[i].vin, vq[i].instr, pc, 0, 0, vq[i].wen, vq[i].wrd, vq[i].wdata);
            step;
            chk($sformatf("v%0d_valid", i), {31'd0, valid_out}, {31'd0, vq[i].evalid});
            chk($sformatf("v%0d_op", i), {25'd0, opcode_out}, {25'd0, vq[i].eop});
            chk($sformatf("v%0d_f3", i), {29'd0, funct3_out}, {29'd0, vq[i].ef3});
            chk($sformatf("v%0d_rd", i), {27'd0, rd_out}, {27'd0, vq[i].erd});
            chk($sformatf("v%0d_rs1", i), rs1_value_out, vq[i].ers1);
            chk($sformatf("v%0d_rs2", i), rs2_value_out, vq[i].ers2);
            chk($sformatf("v%0d_mux", i), mux_result_out, vq[i].emux);
            chk($sformatf("v%0d_imm", i), imm_out, vq[i].eimm);
            chk($sformatf("v%0d_ill", i), {31'd0, illegal_out}, {31'd0, vq[i].eill});
            chk($sformatf("v%0d_pc", i), pc_out, pc);
        end

        // Stall for three cycles with changing input and a writeback to the held rs1.
        drive(1, 32'h4041D113, 32'h2000, 0, 0, 0, 0, 32'h0);
        step;
        chk("srai_f7", {25'd0, funct7_out}, 32'h20);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] junk [0:2];
            junk[0] = 32'h0000007F; junk[1] = 32'hABCDE0B7; junk[2] = 32'h00528333;
            drive(1, junk[k], 32'h3000 + 32'(k), 1, 0, (k == 0), 5'd3, 32'h00000099);
            #1;
            chk($sformatf("stall%0d_ready", k), {31'd0, instr_ready_out}, 32'd0);
            step;
            chk($sformatf("stall%0d_valid", k), {31'd0, valid_out}, 32'd1);
            chk($sformatf("stall%0d_op", k), {25'd0, opcode_out}, 32'h13);
            chk($sformatf("stall%0d_mux", k), mux_result_out, 32'h00000404);
            chk($sformatf("stall%0d_rs1", k), rs1_value_out, 32'h00000010);
            chk($sformatf("stall%0d_pc", k), pc_out, 32'h2000);
        end
        drive(1, 32'h403284B3, 32'h2004, 0, 0, 0, 0, 32'h0);
        step;
        chk("post_stall_rs1", rs1_value_out, 32'h00001234);
        chk("post_stall_rs2", rs2_value_out, 32'h00000099);
        chk("post_stall_valid", {31'd0, valid_out}, 32'd1);

        drive(1, 32'hFFB00093, 32'h2008, 1, 1, 0, 0, 32'h0);
        step;
        chk("flush_stall_valid", {31'd0, valid_out}, 32'd0);

        drive(1, 32'h403284B3, 32'h200C, 0, 0, 0, 0, 32'h0);
        step;
        chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        rst_in = 1'b1;
        drive(1, 32'h403284B3, 32'h2010, 1, 0, 0, 0, 32'h0);
        step;
        chk("rst_stall_ready", {31'd0, instr_ready_out}, 32'd0);
        chk("rst_stall_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_stall_rs1", rs1_value_out, 32'h0);
        chk("rst_stall_mux", mux_result_out, 32'h0);
        chk("rst_stall_pc", pc_out, 32'h0);
        rst_in = 1'b0;
        drive(1, 32'h403284B3, 32'h2014, 0, 0, 0, 0, 32'h0);
        step;
        chk("after_rst_rs1", rs1_value_out, 32'h0);
        chk("after_rst_rs2", rs2_value_out, 32'h0);
        chk("after_rst_valid", {31'd0, valid_out}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the CMPE 140 RISC-V core; sits directly upstream of the ALU. Each accepted 32-bit RV32I instruction is decoded, its source registers are read from an internal 32x32 register file, and its immediate is generated. The result is registered into a one-entry pipeline register whose outputs feed the ALU's opcode/funct3/funct7/rs1/operand-B inputs. The block also owns the register-file write port used by writeback, and supports stall and flush from downstream/control.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk_in  input  1  single clock; all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- instr_valid_in  input  1  instr_in/pc_in carry a valid instruction this cycle
- instr_in  input  32  raw instruction word
- pc_in  input  32  address of instr_in
- instr_ready_out  output  1  stage accepts input this cycle; combinational, = !stall_in
- stall_in  input  1  hold pipeline register contents
- flush_in  input  1  kill the instruction in the pipeline register
- wb_en_in  input  1  register-file write enable
- wb_rd_in  input  5  write destination
- wb_data_in  input  32  write data
- valid_out  output  1  pipeline register holds a live instruction
- opcode_out  output  7  instr[6:0]
- funct3_out  output  3  instr[14:12]
- funct7_out  output  7  instr[31:25]
- rd_out  output  5  instr[11:7]
- rs1_value_out  output  32  value of x[rs1]
- rs2_value_out  output  32  value of x[rs2] (store data, branch compare)
- mux_result_out  output  32  ALU operand B (rs2 value or immediate)
- imm_out  output  32  sign-extended immediate for the decoded format
- pc_out  output  32  PC of the registered instruction
- illegal_out  output  1  registered instruction is unsupported

## Operation
- Register file: x0 reads 0; writes to x0 are discarded. Write on rising edge when wb_en_in, independent of stall/flush.
- Read bypass: if wb_en_in && wb_rd_in != 0 && wb_rd_in == rs, the read returns wb_data_in (write-before-read in the same cycle).
- Immediates, all sign-extended from instr[31]: I (0010011, 0000011, 1100111); S (0100011); B (1100011, bit0 = 0); U (0110111, 0010111, low 12 bits zero); J (1101111, bit0 = 0); R-type imm = 0.
- Operand B: mux_result_out = rs2 value for 0110011 and 1100011; imm otherwise. For SRAI, the I-imm keeps bits [11:5] = 0100000, so the ALU's nonzero-[11:5] arithmetic-shift test holds. For SRLI/SLLI, [11:5] = 0.
- Illegal: opcode outside the nine above; or 0110011 with funct7 not 0000000/0100000; or funct7 = 0100000 with funct3 not 000/101. Illegal instructions still register with valid_out = 1 and illegal_out = 1.
- Pipeline register update priority at each edge: rst_in > flush_in > stall_in > load.
  - rst: all outputs 0.
  - flush: valid_out <= 0, other fields don't-care (implement as hold).
  - stall: hold all.
  - load: capture decode; valid_out <= instr_valid_in.

## Timing
- Reset: all registered outputs and all 31 registers cleared to 0 in the cycle rst_in is sampled high. instr_ready_out follows stall_in even during reset.
- Latency: 1 cycle. Instruction presented at edge N appears on outputs after edge N.
- Handshake: an input is consumed when instr_valid_in && instr_ready_out. Upstream holds instr_in while instr_ready_out = 0.
- Flush and stall together: flush wins, valid_out drops.
- rs values are sampled at the load edge. A write at the same edge to that rs is bypassed. Later writes do not update a stalled entry (hazards are handled downstream).
- rst_in mid-stall: clears immediately, no pending state survives.

## Test plan
- Reset: rst_in = 1 for 2 cycles, then read x1..x31 via R-type → all outputs 0, valid_out = 0, all reads 0.
- ADDI x1,x0,-5 (0xFFB00093) → next cycle: opcode_out = 0x13, funct3_out = 0, mux_result_out = 0xFFFFFFFB, rs1_value_out = 0, valid_out = 1.
- Bypass: write x5 = 0x1234 with wb_en_in while loading ADD x6,x5,x5 in the same cycle → rs1_value_out = mux_result_out = 0x1234. A write to x0 followed by a read of x0 → 0.
- SRAI x2,x3,4 (0x4041D113) → mux_result_out = 0x00000404 ([11:5] nonzero). BEQ with offset -8 → imm_out = 0xFFFFFFF8, mux_result_out = rs2 value.
- Stall 3 cycles with new instr_in changing → outputs held. Stall + flush in the same cycle → valid_out = 0 next cycle.
- Opcode 0x7F, and R-type funct7 = 0x01 → valid_out = 1, illegal_out = 1. LUI 0xABCDE0B7 → imm_out = 0xABCDE000.
